// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared defaults and queue-entry type for the register-file write arbiter
package rf_wb_arbiter_pkg;
    localparam int WIDTH_D = 32;
    localparam int REG_ADDR_D = 5;
    localparam int QDEPTH_D = 4;
    typedef struct packed {
        logic live;
        logic [REG_ADDR_D-1:0] dest;
        logic [WIDTH_D-1:0] data;
    } q_entry_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: pipeline writeback, MDU result, register-file write and hazard-probe signals
interface rf_wb_arbiter_if
    import rf_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int REG_ADDR = REG_ADDR_D
);
    logic WB_RegWrite;
    logic [REG_ADDR-1:0] WB_WriteReg;
    logic [WIDTH-1:0] WB_Result;
    logic MD_Valid;
    logic [REG_ADDR-1:0] MD_Dest;
    logic [WIDTH-1:0] MD_Data;
    logic MD_Ready;
    logic [REG_ADDR-1:0] A3;
    logic WE3;
    logic [WIDTH-1:0] WD3;
    logic [REG_ADDR-1:0] Chk1;
    logic [REG_ADDR-1:0] Chk2;
    logic Busy1;
    logic Busy2;
    logic Q_Empty;
    modport master (
        output WB_RegWrite, WB_WriteReg, WB_Result, MD_Valid, MD_Dest, MD_Data, Chk1, Chk2,
        input MD_Ready, A3, WE3, WD3, Busy1, Busy2, Q_Empty
    );
    modport slave (
        input WB_RegWrite, WB_WriteReg, WB_Result, MD_Valid, MD_Dest, MD_Data, Chk1, Chk2,
        output MD_Ready, A3, WE3, WD3, Busy1, Busy2, Q_Empty
    );
endinterface

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: ordered MDU result queue with kill-by-destination and two pending-register probes
module rf_wb_queue
    import rf_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int REG_ADDR = REG_ADDR_D,
    parameter int QDEPTH = QDEPTH_D
) (
    input logic CLK,
    input logic RST,
    input logic push,
    input logic [REG_ADDR-1:0] push_dest,
    input logic [WIDTH-1:0] push_data,
    input logic pop,
    input logic kill,
    input logic [REG_ADDR-1:0] kill_dest,
    input logic [REG_ADDR-1:0] chk1,
    input logic [REG_ADDR-1:0] chk2,
    output logic busy1,
    output logic busy2,
    output logic head_live,
    output logic [REG_ADDR-1:0] head_dest,
    output logic [WIDTH-1:0] head_data,
    output logic empty,
    output logic full
);
    localparam int PW = $clog2(QDEPTH);
    logic [QDEPTH-1:0] live;
    logic [REG_ADDR-1:0] dest [QDEPTH];
    logic [WIDTH-1:0] data [QDEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0] count;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (PW+1)'(QDEPTH);
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head_live = live[rptr];
    assign head_dest = dest[rptr];
    assign head_data = data[rptr];
    // Kill runs before the push so an entry enqueued this cycle stays live.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            live <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++)
                if (kill && dest[i] == kill_dest) live[i] <= 1'b0;
            if (do_pop) begin
                live[rptr] <= 1'b0;
                rptr <= rptr + 1'b1;
            end
            if (do_push) begin
                live[wptr] <= 1'b1;
                dest[wptr] <= push_dest;
                data[wptr] <= push_data;
                wptr <= wptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end
    // Popped and empty slots always have live=0, so no occupancy qualification is needed.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            busy1 = busy1 | (live[i] && dest[i] == chk1 && chk1 != '0);
            busy2 = busy2 | (live[i] && dest[i] == chk2 && chk2 != '0);
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges pipeline writeback with queued MDU results onto the single register-file write port
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int REG_ADDR = REG_ADDR_D,
    parameter int QDEPTH = QDEPTH_D
) (
    input logic CLK,
    input logic RST,
    rf_wb_arbiter_if.slave bus
);
    logic wb_wr, pop, q_wr, ready, push;
    logic head_live, empty, full, busy1, busy2;
    logic [REG_ADDR-1:0] head_dest;
    logic [WIDTH-1:0] head_data;
    assign wb_wr = RST && bus.WB_RegWrite && bus.WB_WriteReg != '0;
    assign pop = RST && !wb_wr && !empty;
    assign q_wr = pop && head_live;
    assign ready = RST && !full;
    assign push = bus.MD_Valid && ready && bus.MD_Dest != '0;
    rf_wb_queue #(.WIDTH(WIDTH), .REG_ADDR(REG_ADDR), .QDEPTH(QDEPTH)) u_queue (
        .CLK(CLK),
        .RST(RST),
        .push(push),
        .push_dest(bus.MD_Dest),
        .push_data(bus.MD_Data),
        .pop(pop),
        .kill(wb_wr),
        .kill_dest(bus.WB_WriteReg),
        .chk1(bus.Chk1),
        .chk2(bus.Chk2),
        .busy1(busy1),
        .busy2(busy2),
        .head_live(head_live),
        .head_dest(head_dest),
        .head_data(head_data),
        .empty(empty),
        .full(full)
    );
    assign bus.MD_Ready = ready;
    assign bus.WE3 = wb_wr || q_wr;
    assign bus.A3 = wb_wr ? bus.WB_WriteReg : q_wr ? head_dest : '0;
    assign bus.WD3 = wb_wr ? bus.WB_Result : q_wr ? head_data : '0;
    assign bus.Busy1 = RST && busy1;
    assign bus.Busy2 = RST && busy2;
    assign bus.Q_Empty = !RST || empty;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed stimulus with a write-order scoreboard checked by an independent monitor
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;
    rf_wb_arbiter_if #(.WIDTH(WIDTH_D), .REG_ADDR(REG_ADDR_D)) bus ();
    rf_wb_arbiter #(.WIDTH(WIDTH_D), .REG_ADDR(REG_ADDR_D), .QDEPTH(QDEPTH_D)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );
    q_entry_t sb [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        q_entry_t e;
        e.live = 1'b1;
        e.dest = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] res,
                         input logic mv, input logic [4:0] md, input logic [31:0] mdd);
        bus.WB_RegWrite = we;
        bus.WB_WriteReg = wr;
        bus.WB_Result = res;
        bus.MD_Valid = mv;
        bus.MD_Dest = md;
        bus.MD_Data = mdd;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge CLK) begin
        if (bus.WE3) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got A3=%0d WD3=%0h expected no write", bus.A3, bus.WD3);
            end else begin
                q_entry_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.A3), 32'(e.dest));
                chk("wr_data", bus.WD3, e.data);
            end
        end
    end

    initial begin
        drive(1'b1, 5'd4, 32'h4444, 1'b1, 5'd7, 32'h7777);
        bus.Chk1 = 5'd7;
        bus.Chk2 = 5'd0;
        tick();
        @(negedge CLK);
        chk("rst_we3", 32'(bus.WE3), 0);
        chk("rst_a3", 32'(bus.A3), 0);
        chk("rst_wd3", bus.WD3, 0);
        chk("rst_ready", 32'(bus.MD_Ready), 0);
        chk("rst_empty", 32'(bus.Q_Empty), 1);
        chk("rst_busy1", 32'(bus.Busy1), 0);
        tick();
        RST = 1'b1;
        // Pipeline write, then a suppressed r0 write.
        drive(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        exp_wr(5'd8, 32'hDEADBEEF);
        @(negedge CLK);
        chk("wb_we3", 32'(bus.WE3), 1);
        tick();
        drive(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        chk("r0_we3", 32'(bus.WE3), 0);
        chk("r0_a3", 32'(bus.A3), 0);
        tick();
        // Single MDU result, drained the cycle after accept.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h12345678);
        bus.Chk1 = 5'd5;
        @(negedge CLK);
        chk("md_ready", 32'(bus.MD_Ready), 1);
        chk("md_busy_pre", 32'(bus.Busy1), 0);
        chk("md_empty_pre", 32'(bus.Q_Empty), 1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_wr(5'd5, 32'h12345678);
        @(negedge CLK);
        chk("md_busy", 32'(bus.Busy1), 1);
        chk("md_we3", 32'(bus.WE3), 1);
        chk("md_empty", 32'(bus.Q_Empty), 0);
        tick();
        @(negedge CLK);
        chk("md_empty_post", 32'(bus.Q_Empty), 1);
        chk("md_busy_post", 32'(bus.Busy1), 0);
        chk("idle_we3", 32'(bus.WE3), 0);
        chk("idle_wd3", bus.WD3, 0);
        tick();
        // MDU result to r0 completes the handshake but is dropped.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBAD0);
        @(negedge CLK);
        chk("r0md_ready", 32'(bus.MD_Ready), 1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        chk("r0md_empty", 32'(bus.Q_Empty), 1);
        tick();
        // Fill the queue while the pipeline writes every cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(10 + i), 32'h100 + i, 1'b1, 5'(20 + i), 32'h200 + i);
            exp_wr(5'(10 + i), 32'h100 + i);
            @(negedge CLK);
            chk("fill_ready", 32'(bus.MD_Ready), 1);
            tick();
        end
        drive(1'b1, 5'd14, 32'h104, 1'b1, 5'd24, 32'h204);
        exp_wr(5'd14, 32'h104);
        bus.Chk1 = 5'd20;
        bus.Chk2 = 5'd23;
        @(negedge CLK);
        chk("full_ready", 32'(bus.MD_Ready), 0);
        chk("full_busy1", 32'(bus.Busy1), 1);
        chk("full_busy2", 32'(bus.Busy2), 1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) exp_wr(5'(20 + i), 32'h200 + i);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("drain_we3", 32'(bus.WE3), 1);
            if (i == 0) chk("drain_ready_full", 32'(bus.MD_Ready), 0);
            if (i == 1) chk("drain_ready_freed", 32'(bus.MD_Ready), 1);
            tick();
        end
        @(negedge CLK);
        chk("drain_empty", 32'(bus.Q_Empty), 1);
        chk("drain_busy2", 32'(bus.Busy2), 0);
        tick();
        // WAW kill: pipeline write to r9 kills the queued r9 result.
        bus.Chk2 = 5'd0;
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
        exp_wr(5'd1, 32'h11);
        tick();
        drive(1'b1, 5'd9, 32'hAAAA, 1'b0, 5'd0, 32'h0);
        exp_wr(5'd9, 32'hAAAA);
        bus.Chk1 = 5'd9;
        @(negedge CLK);
        chk("kill_busy_pre", 32'(bus.Busy1), 1);
        tick();
        drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0);
        exp_wr(5'd2, 32'h22);
        @(negedge CLK);
        chk("kill_busy_post", 32'(bus.Busy1), 0);
        chk("kill_not_empty", 32'(bus.Q_Empty), 0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        chk("kill_pop_we3", 32'(bus.WE3), 0);
        tick();
        @(negedge CLK);
        chk("kill_empty", 32'(bus.Q_Empty), 1);
        tick();
        // Same-cycle pipeline write and enqueue to r3: the MDU result is newer.
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 32'h3333);
        exp_wr(5'd3, 32'h33);
        bus.Chk1 = 5'd3;
        @(negedge CLK);
        chk("same_busy_pre", 32'(bus.Busy1), 0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_wr(5'd3, 32'h3333);
        @(negedge CLK);
        chk("same_we3", 32'(bus.WE3), 1);
        chk("same_busy", 32'(bus.Busy1), 1);
        tick();
        // Reset with three queued entries discards them.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd4, 32'h40 + i, 1'b1, 5'(25 + i), 32'h250 + i);
            exp_wr(5'd4, 32'h40 + i);
            tick();
        end
        RST = 1'b0;
        drive(1'b1, 5'd4, 32'h4F, 1'b0, 5'd0, 32'h0);
        bus.Chk1 = 5'd25;
        @(negedge CLK);
        chk("rst2_busy", 32'(bus.Busy1), 0);
        chk("rst2_empty", 32'(bus.Q_Empty), 1);
        chk("rst2_ready", 32'(bus.MD_Ready), 0);
        chk("rst2_we3", 32'(bus.WE3), 0);
        tick();
        RST = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("post_rst_ready", 32'(bus.MD_Ready), 1);
            chk("post_rst_empty", 32'(bus.Q_Empty), 1);
            chk("post_rst_we3", 32'(bus.WE3), 0);
            tick();
        end
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-side arbiter for the single register-file write port (A3/WE3/WD3) in the pipelined MIPS core. It merges the in-order pipeline writeback stream with results from the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small ordered queue and drained on cycles where the pipeline does not write. It also exposes per-register "pending" flags so the hazard unit can stall readers of registers with queued results.

## Interface
Parameters:
- WIDTH, 32, data width
- REG_ADDR, 5, register address width
- QDEPTH, 4, MDU result queue entries (power of two, ≥2)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-low
- WB_RegWrite  in  1  pipeline writeback enable
- WB_WriteReg  in  REG_ADDR  pipeline destination register
- WB_Result  in  WIDTH  pipeline writeback data
- MD_Valid  in  1  MDU result offered
- MD_Dest  in  REG_ADDR  MDU destination register
- MD_Data  in  WIDTH  MDU result data
- MD_Ready  out  1  queue can accept; transfer when MD_Valid & MD_Ready
- A3  out  REG_ADDR  register-file write address
- WE3  out  1  register-file write enable
- WD3  out  WIDTH  register-file write data
- Chk1, Chk2  in  REG_ADDR  register numbers probed by the hazard unit
- Busy1, Busy2  out  1  live queued entry targets Chk1 / Chk2
- Q_Empty  out  1  no entries in queue (live or killed)

## Operation
- Queue: FIFO of QDEPTH entries {live, dest, data}, with read/write pointers and a count.
- Pipeline priority:
  - When WB_RegWrite=1 and WB_WriteReg≠0: WE3=1, A3=WB_WriteReg, WD3=WB_Result, combinationally in the same cycle.
  - The pipeline is never stalled by this block.
- Register 0 writes are suppressed, because the register file does not hardwire r0:
  - Pipeline writes to r0 give WE3=0.
  - MDU results with MD_Dest=0 are accepted (handshake completes) but not enqueued.
- Drain: when the pipeline is not writing (WB_RegWrite=0 or WB_WriteReg=0) and the queue is non-empty, pop the head.
  - Live head: WE3=1, A3=head.dest, WD3=head.data.
  - Killed head: pop with WE3=0.
  - One pop per cycle.
- WAW kill: when the pipeline writes register R≠0, every entry already queued at the start of that cycle with dest=R has its live bit cleared. The pipeline instruction is younger.
- Enqueue: on MD_Valid & MD_Ready & MD_Dest≠0, write {live=1, MD_Dest, MD_Data} at the tail.
  - An entry enqueued in the same cycle as a pipeline write to the same R stays live (MDU result is newer).
- MD_Ready = RST & (count < QDEPTH), where count is evaluated at cycle start. There is no same-cycle pop-to-push pass-through.
- Busy1 = 1 iff Chk1≠0 and some live entry has dest=Chk1. Busy2 is the same for Chk2. Both are combinational from queue state and are not affected by same-cycle enqueue or kill.
- Idle outputs: with no pipeline write and an empty queue, WE3=0 and A3/WD3 = 0.

## Timing
- Reset (RST=0 at edge): pointers, count and live bits are cleared.
  - While RST=0: WE3=0, A3=0, WD3=0, MD_Ready=0, Busy1/2=0, Q_Empty=1.
  - Reset mid-drain discards all queued entries.
- Pipeline write latency: 0 cycles, a combinational path to A3/WE3/WD3.
- MDU result latency: at least 1 cycle from accept to WE3, i.e. the next cycle if the pipeline is idle. There is no empty-queue bypass.
- Starvation: a queued entry waits as long as the pipeline writes every cycle. The hazard unit uses Busy to stall dependent readers.
- Full and pop in the same cycle: MD_Ready stays 0 that cycle; the freed slot becomes visible next cycle.
- Pointer wrap: modulo QDEPTH. Count distinguishes full from empty.

## Structure
- Shared core package holds WIDTH, REG_ADDR, QDEPTH defaults and the queue-entry struct {live, dest, data}.
- One sub-module, rf_wb_queue, contains storage, pointers, count, kill-by-dest and the two Busy comparators.
- The top level holds the priority mux and r0 filtering.

## Test plan
- Reset, then WB_RegWrite=1, WB_WriteReg=8, WB_Result=0xDEADBEEF -> same cycle WE3=1, A3=8, WD3=0xDEADBEEF. A following WB write to r0 gives WE3=0.
- MDU accept dest=5, data=0x12345678 with pipeline idle -> Busy(Chk=5)=1 for one cycle, then next cycle WE3=1, A3=5; after that Q_Empty=1 and Busy=0.
- Pipeline writes every cycle while the MDU pushes 4 results -> MD_Ready=0 after the 4th, no WE3 from the queue. The pipeline then goes idle -> 4 writes drain in FIFO order over 4 cycles.
- Queue holds dest=9 (live) and the pipeline writes r9=0xAAAA -> entry killed, Busy(9) drops next cycle, a later drain pops it with WE3=0, and r9 keeps 0xAAAA.
- Same cycle: pipeline writes r3 and the MDU enqueues dest=3 -> the new entry stays live and is written on the next idle cycle.
- Queue holds 3 entries and RST=0 for one edge -> Q_Empty=1, MD_Ready=0 during reset, MD_Ready=1 after release, and no stale WE3 afterwards.
